cpu_mem_subsystem: RTL and testbench



---
 rtl/cpu_mem_pkg.sv | 35 +++
 rtl/data_ram_bank.sv | 38 +++
 rtl/cpu_mem_subsystem.sv | 54 +++++
 tb/tb_cpu_mem_subsystem.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared widths, RV32 opcode constants and the fixed ROM program
package cpu_mem_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [31:0] NOP = 32'h00000013;

    // Test program; every word past the last entry reads as NOP.
    localparam logic [31:0] ROM_PROGRAM [0:7] = '{
        32'h00500093,   // addi x1,x0,5
        32'h00700113,   // addi x2,x0,7
        32'h002081B3,   // add  x3,x1,x2
        32'h00302223,   // sw   x3,4(x0)
        32'h00402203,   // lw   x4,4(x0)
        32'h001202B3,   // add  x5,x4,x1
        32'h00502423,   // sw   x5,8(x0)
        NOP
    };

    function automatic logic [31:0] rom_word(input logic [31:0] idx);
        logic [2:0] slot;
        slot = idx[2:0];
        if (idx < 32'd8) begin
            return ROM_PROGRAM[slot];
        end
        return NOP;
    endfunction

endpackage

// File: rtl/data_ram_bank.sv
// rtl/data_ram_bank.sv - falling-edge data RAM with gated write port and registered read
module data_ram_bank
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = cpu_mem_pkg::ADDR_W,
    parameter int DATA_W = cpu_mem_pkg::DATA_W
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              write_ok,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic [DATA_W-1:0] q
);

    localparam int DEPTH = 1 << ADDR_W;

    // Power-up contents are zero; reset deliberately leaves the array alone.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    // Read register: old data on read-during-write, cleared while reset is high.
    always_ff @(negedge CLOCK_50) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= mem[address];
        end
    end

    // Write port: stores are dropped before lock and while reset is asserted.
    always_ff @(negedge CLOCK_50) begin
        if (wren && write_ok && !reset) begin
            mem[address] <= data;
        end
    end

endmodule

// File: rtl/cpu_mem_subsystem.sv
// rtl/cpu_mem_subsystem.sv - instruction ROM, falling-edge data RAM and lock generator
module cpu_mem_subsystem
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W      = cpu_mem_pkg::ADDR_W,
    parameter int DATA_W      = cpu_mem_pkg::DATA_W,
    parameter int LOCK_CYCLES = 4
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic [DATA_W-1:0] q,
    output logic              locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCK_CYCLES);

    logic [CNT_W-1:0] lock_cnt;

    // Instruction fetch is a pure lookup of the current pc.
    always_comb begin
        instr = DATA_W'(rom_word(32'(pc)));
    end

    // Saturating count of rising edges since reset was released.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            lock_cnt <= '0;
        end else if (lock_cnt != LOCK_CNT) begin
            lock_cnt <= lock_cnt + CNT_W'(1);
        end
    end

    assign locked = (lock_cnt == LOCK_CNT);

    data_ram_bank #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_data_ram_bank (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .write_ok (locked),
        .address  (address),
        .data     (data),
        .wren     (wren),
        .q        (q)
    );

endmodule

// File: tb/tb_cpu_mem_subsystem.sv
// tb/tb_cpu_mem_subsystem.sv - randomized self-checking bench against a behavioural memory model
module tb_cpu_mem_subsystem;

    localparam int LOCK = 4;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic [4:0]  pc       = '0;
    logic [4:0]  address  = '0;
    logic [31:0] data     = '0;
    logic        wren     = 1'b0;
    logic [31:0] instr;
    logic [31:0] q;
    logic        locked;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_mem [32];
    logic [31:0] rom_exp   [32];
    int          edges_since_release = 0;
    bit          model_locked = 1'b0;

    cpu_mem_subsystem #(
        .ADDR_W      (5),
        .DATA_W      (32),
        .LOCK_CYCLES (LOCK)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .pc       (pc),
        .instr    (instr),
        .address  (address),
        .data     (data),
        .wren     (wren),
        .q        (q),
        .locked   (locked)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full core cycle: drive after the rising edge, check q after the
    // falling edge, check locked after the next rising edge.
    task automatic cycle(input bit rst, input bit wr, input logic [4:0] a,
                         input logic [31:0] d, input string tag);
        logic [31:0] exp_q;
        reset   = rst;
        wren    = wr;
        address = a;
        data    = d;
        @(negedge CLOCK_50);
        #1;
        exp_q = rst ? 32'h0 : model_mem[a];
        if (wr && model_locked && !rst) begin
            model_mem[a] = d;
        end
        check({tag, ".q"}, q, exp_q);
        @(posedge CLOCK_50);
        #1;
        if (rst) begin
            edges_since_release = 0;
        end else begin
            edges_since_release++;
        end
        model_locked = !rst && (edges_since_release >= LOCK);
        check({tag, ".locked"}, {31'b0, locked}, {31'b0, model_locked});
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            model_mem[i] = 32'h0;
            rom_exp[i]   = 32'h00000013;
        end
        rom_exp[0] = 32'h00500093;
        rom_exp[1] = 32'h00700113;
        rom_exp[2] = 32'h002081B3;
        rom_exp[3] = 32'h00302223;
        rom_exp[4] = 32'h00402203;
        rom_exp[5] = 32'h001202B3;
        rom_exp[6] = 32'h00502423;

        // Reset held for two cycles: q and locked both zero.
        cycle(1'b1, 1'b0, 5'd0, 32'h0, "reset0");
        cycle(1'b1, 1'b1, 5'd1, 32'hDEAD, "reset1");

        // ROM sweep, purely combinational.
        for (int i = 0; i < 32; i++) begin
            pc = 5'(i);
            #1;
            check($sformatf("rom[%0d]", i), instr, rom_exp[i]);
        end

        // Release; stores during the pre-lock cycles must be dropped.
        for (int i = 0; i < LOCK; i++) begin
            cycle(1'b0, 1'b1, 5'd5, 32'hFF, "prelock");
        end

        // Store then load.
        cycle(1'b0, 1'b1, 5'd4, 32'd12, "store4");
        cycle(1'b0, 1'b0, 5'd4, 32'h0, "load4");
        check("load4.value", q, 32'd12);
        cycle(1'b0, 1'b0, 5'd8, 32'h0, "load8");
        check("load8.value", q, 32'h0);
        cycle(1'b0, 1'b0, 5'd5, 32'h0, "load5");
        check("load5.value", q, 32'h0);

        // Read-during-write returns old data, new data the following edge.
        cycle(1'b0, 1'b1, 5'd3, 32'hA5, "rdw.pre");
        cycle(1'b0, 1'b1, 5'd3, 32'h5A, "rdw.old");
        check("rdw.old.value", q, 32'hA5);
        cycle(1'b0, 1'b0, 5'd3, 32'h0, "rdw.new");
        check("rdw.new.value", q, 32'h5A);

        // Back-to-back writes to the same word: last write wins.
        cycle(1'b0, 1'b1, 5'd7, 32'h1, "lww.a");
        cycle(1'b0, 1'b1, 5'd7, 32'h2, "lww.b");
        cycle(1'b0, 1'b0, 5'd7, 32'h0, "lww.rd");
        check("lww.value", q, 32'h2);

        // Reset mid-run with a store pending; contents survive.
        cycle(1'b1, 1'b1, 5'd4, 32'h99, "midrst0");
        cycle(1'b1, 1'b1, 5'd4, 32'h77, "midrst1");
        for (int i = 0; i < LOCK; i++) begin
            cycle(1'b0, 1'b0, 5'd0, 32'h0, "relock");
        end
        cycle(1'b0, 1'b0, 5'd4, 32'h0, "after_rst");
        check("after_rst.value", q, 32'd12);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)),
                  $urandom,
                  "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
